fp_iterative_butterfly: RTL
===========================

Name: fp_iterative_butterfly

Overview:
- Radix-2 decimation-in-time FFT butterfly stage. It sits directly downstream of the iterative fixed-point complex multiplier.
- Accepts operands a, b and twiddle w, and issues b·w to an external complex multiplier through a val/rdy request/response pair.
- Holds a while the multiplier runs, then produces x = a + w·b and y = a − w·b.
- One butterfly is in flight at a time. The block pairs with the multiplier's single-transaction handshake.

Parameters:
- n, 32, total bit width of every real/imaginary component (two's complement fixed point)
- d, 16, number of fractional bits. Passed through for consistency only; the block performs no scaling.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- recv_val  in  1  input operands valid
- recv_rdy  out  1  block can accept operands
- ar, ac  in  n  operand a, real/imaginary
- br, bc  in  n  operand b, real/imaginary
- wr, wc  in  n  twiddle w, real/imaginary
- mul_req_val  out  1  multiplier request valid
- mul_req_rdy  in  1  multiplier accepts request
- mul_ar, mul_ac  out  n  multiplier operand 1 (= latched b)
- mul_br, mul_bc  out  n  multiplier operand 2 (= latched w)
- mul_resp_val  in  1  multiplier product valid
- mul_resp_rdy  out  1  block consumes product
- mul_cr, mul_cc  in  n  product w·b, real/imaginary
- send_val  out  1  results valid
- send_rdy  in  1  downstream accepts results
- xr, xc  out  n  x = a + w·b
- yr, yc  out  n  y = a − w·b

Behaviour:
- Reset is synchronous, active-high on clk.
  - State goes to IDLE.
  - All internal operand registers and xr, xc, yr, yc reset to 0.
  - In reset: recv_rdy=1 (IDLE decode); mul_req_val=0, mul_resp_rdy=0, send_val=0.
  - Reset mid-operation abandons the transaction immediately. Any product arriving afterwards is ignored, because mul_resp_rdy=0 in IDLE.
- FSM states are IDLE, ISSUE, WAIT, DONE. Outputs are Moore decode of state only.
- IDLE
  - Outputs: recv_rdy=1, all other handshake outputs 0.
  - recv_val=1: latch ar, ac, br, bc, wr, wc; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE
  - Outputs: mul_req_val=1. mul_ar/mul_ac/mul_br/mul_bc driven from the latched b and w, and held stable until accepted.
  - mul_req_rdy=1: go to WAIT. Otherwise hold ISSUE.
- WAIT
  - Outputs: mul_resp_rdy=1.
  - mul_resp_val=1: register the results and go to DONE.
    - xr = a_r + mul_cr, xc = a_c + mul_cc
    - yr = a_r − mul_cr, yc = a_c − mul_cc
  - mul_resp_val and mul_req_rdy asserted in the same cycle as entry are handled per state; WAIT looks only at mul_resp_val.
- DONE
  - Outputs: send_val=1; xr/xc/yr/yc stable.
  - send_rdy=1: go to IDLE. Otherwise hold DONE indefinitely (backpressure).
- No input bypass: recv_rdy=0 in DONE, so a new transaction is accepted no earlier than the cycle after the send fires.
- Arithmetic
  - n-bit modular two's-complement add/subtract. Overflow wraps; there is no saturation and no flag.
  - No rescaling: the multiplier output is already in n.d format.
- Latency, with zero-wait multiplier handshakes:
  - accept (cycle 0) → ISSUE (1) → WAIT (2) → product cycle k → DONE (k+1).
  - send_val rises 1 cycle after mul_resp_val is seen.
- Outputs xr/xc/yr/yc are registered and retain their last value after the send until the next product is captured.
- Unknown or illegal state encoding returns to IDLE.

Test Plan:
- Basic butterfly, n=32, d=16, mock multiplier returns product 0x00008000 + 0x00004000j:
  - a = 0x00010000 + 0x00020000j.
  - Required: xr=0x00018000, xc=0x00024000, yr=0x00008000, yc=0x0001C000.
  - Mock must see mul_ar/mul_ac = b and mul_br/mul_bc = w exactly.
- Wrap-around: ar=0x7FFF0000, mul_cr=0x00020000 → xr=0x80010000, yr=0x7FFD0000. No saturation.
- Backpressure on three fronts:
  - mul_req_rdy held low 5 cycles → mul_req_val stays 1 and operands are stable.
  - mul_resp_val delayed 20 cycles → mul_resp_rdy stays 1.
  - send_rdy low 7 cycles → send_val and results stay stable.
  - After all three release, the transaction completes with correct values.
- Back-to-back: 4 random transactions with recv_val held high and all other rdy signals high.
  - Each accepted only when recv_rdy=1.
  - Results match a golden model using the real complex multiplier instance.
  - Minimum spacing between accepts is 4 cycles.
- Reset in WAIT:
  - Assert reset, then pulse mul_resp_val after deassert.
  - Required: block in IDLE, recv_rdy=1, send_val=0, outputs 0, stale product ignored.
- Idle stability: recv_val=0 for 50 cycles → no mul_req_val, no send_val, outputs unchanged.

Source files
------------

// File: rtl/fp_iterative_butterfly.sv
// Radix-2 DIT butterfly: x = a + w*b, y = a - w*b. The product w*b comes from an
// external complex multiplier over a request/response handshake; one butterfly in flight.
module fp_iterative_butterfly #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic         mul_req_val,
  input  logic         mul_req_rdy,
  output logic [n-1:0] mul_ar,
  output logic [n-1:0] mul_ac,
  output logic [n-1:0] mul_br,
  output logic [n-1:0] mul_bc,
  input  logic         mul_resp_val,
  output logic         mul_resp_rdy,
  input  logic [n-1:0] mul_cr,
  input  logic [n-1:0] mul_cc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] xr,
  output logic [n-1:0] xc,
  output logic [n-1:0] yr,
  output logic [n-1:0] yc
);

  // The fraction width only documents the n.d format; no rescaling happens here.
  if (d < 0 || d > n) begin : g_bad_fraction
    $error("fp_iterative_butterfly: fractional bits d must lie in 0..n");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_r;
  logic [n-1:0] ar_r;
  logic [n-1:0] ac_r;

  // FSM: handshake outputs are registered together with the state they decode.
  // The latched b and w feed the multiplier directly from their registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      recv_rdy     <= 1'b1;
      mul_req_val  <= 1'b0;
      mul_resp_rdy <= 1'b0;
      send_val     <= 1'b0;
      ar_r         <= {n{1'b0}};
      ac_r         <= {n{1'b0}};
      mul_ar       <= {n{1'b0}};
      mul_ac       <= {n{1'b0}};
      mul_br       <= {n{1'b0}};
      mul_bc       <= {n{1'b0}};
      xr           <= {n{1'b0}};
      xc           <= {n{1'b0}};
      yr           <= {n{1'b0}};
      yc           <= {n{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (recv_val) begin
            ar_r        <= ar;
            ac_r        <= ac;
            mul_ar      <= br;
            mul_ac      <= bc;
            mul_br      <= wr;
            mul_bc      <= wc;
            state_r     <= ISSUE;
            recv_rdy    <= 1'b0;
            mul_req_val <= 1'b1;
          end
        end
        ISSUE: begin
          if (mul_req_rdy) begin
            state_r      <= WAIT;
            mul_req_val  <= 1'b0;
            mul_resp_rdy <= 1'b1;
          end
        end
        WAIT: begin
          // Modular n-bit add/subtract: overflow wraps silently.
          if (mul_resp_val) begin
            xr           <= ar_r + mul_cr;
            xc           <= ac_r + mul_cc;
            yr           <= ar_r - mul_cr;
            yc           <= ac_r - mul_cc;
            state_r      <= DONE;
            mul_resp_rdy <= 1'b0;
            send_val     <= 1'b1;
          end
        end
        DONE: begin
          if (send_rdy) begin
            state_r  <= IDLE;
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          recv_rdy     <= 1'b1;
          mul_req_val  <= 1'b0;
          mul_resp_rdy <= 1'b0;
          send_val     <= 1'b0;
        end
      endcase
    end
  end

endmodule
